// File: rtl/exec_seq_pkg.sv
// Shared types and widths for the execution sequencer.
// EXEC_SEQ_TIMEOUT_EN adds the FAULT state used by the bus-wait watchdog.
package exec_seq_pkg;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    FETCH_LO = 3'd0,
    FETCH_HI = 3'd1,
    DECODE   = 3'd2,
    MEM      = 3'd3,
    EXEC     = 3'd4,
    HALT     = 3'd5
`ifdef EXEC_SEQ_TIMEOUT_EN
    ,
    FAULT    = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/exec_seq_watchdog.sv
// Per-transfer bus wait counter; expired flags the cycle in which the
// TIMEOUT_CYCLES-th consecutive un-acked request cycle is reached.
module exec_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Request always drops for at least one cycle between transfers, so
  // clearing on !active restarts the count for every new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (!active) count <= '0;
    else if (!ack)    count <= count + 1'b1;
  end

  assign expired = active && !ack && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/memory/execute control FSM, sole bus master.
// Define EXEC_SEQ_TIMEOUT_EN to enable the bus-ack watchdog and FAULT state.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pc,
  input  logic [7:0]         cs,
  input  logic [7:0]         ds,
  input  logic               dec_mem_rd,
  input  logic               dec_mem_wr,
  input  logic               dec_halt,
  input  logic [15:0]        dec_addr,
  input  logic [DATA_W-1:0]  st_data,
  input  logic               resume,
  output logic               bus_req,
  output logic               bus_we,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [DATA_W-1:0]  bus_wdata,
  input  logic [DATA_W-1:0]  bus_rdata,
  input  logic               bus_ack,
  output logic [INSTR_W-1:0] instr,
  output logic               execution_signal,
  output logic               mem_src,
  output logic [DATA_W-1:0]  mem_data,
  output logic               halted,
  output logic               fault
);

  state_t state;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("exec_sequencer: TIMEOUT_CYCLES must be nonzero");
  end

`ifdef EXEC_SEQ_TIMEOUT_EN
  logic wd_expired;

  exec_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (bus_req),
    .ack    (bus_ack),
    .expired(wd_expired)
  );
`else
  assign fault = 1'b0;
`endif

  // Fetch states spend one cycle with bus_req low before issuing; that cycle
  // is the mandatory bus idle gap and, in FETCH_LO, samples the committed pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= FETCH_LO;
      bus_req          <= 1'b0;
      bus_we           <= 1'b0;
      bus_addr         <= '0;
      bus_wdata        <= '0;
      instr            <= '0;
      execution_signal <= 1'b0;
      mem_src          <= 1'b0;
      mem_data         <= '0;
      halted           <= 1'b0;
`ifdef EXEC_SEQ_TIMEOUT_EN
      fault            <= 1'b0;
`endif
    end else begin
      execution_signal <= 1'b0;
      mem_src          <= 1'b0;
      case (state)
        FETCH_LO: begin
          if (!bus_req) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= {cs, pc};
          end else if (bus_ack) begin
            instr[15:0] <= bus_rdata;
            bus_req     <= 1'b0;
            state       <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (!bus_req) begin
            bus_req  <= 1'b1;
            bus_addr <= {cs, pc + 16'd2};
          end else if (bus_ack) begin
            instr[31:16] <= bus_rdata;
            bus_req      <= 1'b0;
            state        <= DECODE;
          end
        end
        DECODE: begin
          // DECODE doubles as the idle gap before the data transfer.
          if (dec_halt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (dec_mem_rd) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= {ds, dec_addr};
            state    <= MEM;
          end else if (dec_mem_wr) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= {ds, dec_addr};
            bus_wdata <= st_data;
            state     <= MEM;
          end else begin
            execution_signal <= 1'b1;
            state            <= EXEC;
          end
        end
        MEM: begin
          if (bus_ack) begin
            if (!bus_we) mem_data <= bus_rdata;
            mem_src          <= !bus_we;
            execution_signal <= 1'b1;
            bus_req          <= 1'b0;
            bus_we           <= 1'b0;
            state            <= EXEC;
          end
        end
        EXEC: state <= FETCH_LO;
        HALT: begin
          if (resume) begin
            halted           <= 1'b0;
            execution_signal <= 1'b1;
            state            <= EXEC;
          end
        end
`ifdef EXEC_SEQ_TIMEOUT_EN
        FAULT: state <= FAULT;
`endif
        default: state <= FETCH_LO;
      endcase
`ifdef EXEC_SEQ_TIMEOUT_EN
      if (wd_expired) begin
        bus_req <= 1'b0;
        bus_we  <= 1'b0;
        fault   <= 1'b1;
        state   <= FAULT;
      end
`endif
    end
  end

endmodule
